// File: rtl/reservation_station.sv
// Reservation station: holds issued ALU/branch ops until both operands arrive
// (directly, by same-cycle bypass or CDB wakeup), then dispatches one per cycle.
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_rollback,
  input  logic [ROB_TAG_W-1:0] in_dec_rob_tag,
  input  logic [OP_W-1:0]      in_dec_op,
  input  logic [DATA_W-1:0]    in_dec_value1,
  input  logic [DATA_W-1:0]    in_dec_value2,
  input  logic [ROB_TAG_W-1:0] in_dec_tag1,
  input  logic [ROB_TAG_W-1:0] in_dec_tag2,
  input  logic [DATA_W-1:0]    in_dec_imm,
  input  logic [DATA_W-1:0]    in_dec_pc,
  input  logic [ROB_TAG_W-1:0] in_alu_cdb_tag,
  input  logic [DATA_W-1:0]    in_alu_cdb_value,
  input  logic [ROB_TAG_W-1:0] in_lsb_cdb_tag,
  input  logic [DATA_W-1:0]    in_lsb_cdb_value,
  output logic                 out_full,
  output logic [ROB_TAG_W-1:0] out_alu_rob_tag,
  output logic [OP_W-1:0]      out_alu_op,
  output logic [DATA_W-1:0]    out_alu_value1,
  output logic [DATA_W-1:0]    out_alu_value2,
  output logic [DATA_W-1:0]    out_alu_imm,
  output logic [DATA_W-1:0]    out_alu_pc
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    val;
  } opnd_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob;
    logic [OP_W-1:0]      op;
    opnd_t                s1;
    opnd_t                s2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
  } ent_t;

  ent_t                 ent_q [RS_SIZE];
  ent_t                 ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]   busy_q, busy_d, ready;
  logic                 full_q, full_d;
  logic                 disp_vld, free_vld, issue_en;
  logic [IDX_W-1:0]     disp_idx, free_idx;
  logic [ROB_TAG_W-1:0] tag_q;
  logic [OP_W-1:0]      op_q;
  logic [DATA_W-1:0]    v1_q, v2_q, imm_q, pc_q;

  // A pending operand resolves from the CDB; ALU wins if both buses carry the tag.
  function automatic opnd_t snoop(input opnd_t o,
                                  input logic [ROB_TAG_W-1:0] at, input logic [DATA_W-1:0] av,
                                  input logic [ROB_TAG_W-1:0] lt, input logic [DATA_W-1:0] lv);
    opnd_t r;
    r = o;
    if (o.tag != '0 && o.tag == at) begin
      r.tag = '0;
      r.val = av;
    end else if (o.tag != '0 && o.tag == lt) begin
      r.tag = '0;
      r.val = lv;
    end
    return r;
  endfunction

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_rdy
    assign ready[g] = busy_q[g] && ent_q[g].s1.tag == '0 && ent_q[g].s2.tag == '0;
  end

  always_comb begin
    disp_vld = 1'b0;
    disp_idx = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        disp_vld = 1'b1;
        disp_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign issue_en = (in_dec_rob_tag != '0) && free_vld;

  // Issue only targets a slot free at cycle start, so it never collides with dispatch.
  always_comb begin
    busy_d = busy_q;
    ent_d  = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        ent_d[i].s1 = snoop(ent_q[i].s1, in_alu_cdb_tag, in_alu_cdb_value,
                            in_lsb_cdb_tag, in_lsb_cdb_value);
        ent_d[i].s2 = snoop(ent_q[i].s2, in_alu_cdb_tag, in_alu_cdb_value,
                            in_lsb_cdb_tag, in_lsb_cdb_value);
      end
    end
    if (disp_vld) busy_d[disp_idx] = 1'b0;
    if (issue_en) begin
      busy_d[free_idx]     = 1'b1;
      ent_d[free_idx].rob  = in_dec_rob_tag;
      ent_d[free_idx].op   = in_dec_op;
      ent_d[free_idx].imm  = in_dec_imm;
      ent_d[free_idx].pc   = in_dec_pc;
      ent_d[free_idx].s1   = snoop('{tag: in_dec_tag1, val: in_dec_value1}, in_alu_cdb_tag,
                                   in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value);
      ent_d[free_idx].s2   = snoop('{tag: in_dec_tag2, val: in_dec_value2}, in_alu_cdb_tag,
                                   in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value);
    end
    if (in_rollback) busy_d = '0;
    full_d = ($countones(busy_d) > RS_SIZE - 2);
  end

  always_ff @(posedge clk) begin
    if (rdy) ent_q <= ent_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      full_q <= 1'b0;
      tag_q  <= '0;
      op_q   <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      full_q <= full_d;
      if (in_rollback || !disp_vld) begin
        tag_q <= '0;
      end else begin
        tag_q <= ent_q[disp_idx].rob;
        op_q  <= ent_q[disp_idx].op;
        v1_q  <= ent_q[disp_idx].s1.val;
        v2_q  <= ent_q[disp_idx].s2.val;
        imm_q <= ent_q[disp_idx].imm;
        pc_q  <= ent_q[disp_idx].pc;
      end
    end
  end

  assign out_full        = full_q;
  assign out_alu_rob_tag = tag_q;
  assign out_alu_op      = op_q;
  assign out_alu_value1  = v1_q;
  assign out_alu_value2  = v2_q;
  assign out_alu_imm     = imm_q;
  assign out_alu_pc      = pc_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic, all
// checked every cycle against a slot-array model of the station.
module tb_reservation_station;
  localparam int RS = 16;

  logic        clk, rst, rdy, in_rollback;
  logic [3:0]  in_dec_rob_tag, in_dec_tag1, in_dec_tag2, in_alu_cdb_tag, in_lsb_cdb_tag;
  logic [5:0]  in_dec_op;
  logic [31:0] in_dec_value1, in_dec_value2, in_dec_imm, in_dec_pc;
  logic [31:0] in_alu_cdb_value, in_lsb_cdb_value;
  logic        out_full;
  logic [3:0]  out_alu_rob_tag;
  logic [5:0]  out_alu_op;
  logic [31:0] out_alu_value1, out_alu_value2, out_alu_imm, out_alu_pc;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_rollback(in_rollback),
    .in_dec_rob_tag(in_dec_rob_tag), .in_dec_op(in_dec_op),
    .in_dec_value1(in_dec_value1), .in_dec_value2(in_dec_value2),
    .in_dec_tag1(in_dec_tag1), .in_dec_tag2(in_dec_tag2),
    .in_dec_imm(in_dec_imm), .in_dec_pc(in_dec_pc),
    .in_alu_cdb_tag(in_alu_cdb_tag), .in_alu_cdb_value(in_alu_cdb_value),
    .in_lsb_cdb_tag(in_lsb_cdb_tag), .in_lsb_cdb_value(in_lsb_cdb_value),
    .out_full(out_full), .out_alu_rob_tag(out_alu_rob_tag), .out_alu_op(out_alu_op),
    .out_alu_value1(out_alu_value1), .out_alu_value2(out_alu_value2),
    .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state: one record per slot
  logic        m_busy [RS];
  logic [3:0]  m_rob [RS], m_t1 [RS], m_t2 [RS];
  logic [5:0]  m_op [RS];
  logic [31:0] m_v1 [RS], m_v2 [RS], m_imm [RS], m_pc [RS];
  logic        m_full;
  logic [3:0]  m_tag;
  logic [5:0]  m_oop;
  logic [31:0] m_ov1, m_ov2, m_oimm, m_opc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
    m_full = 1'b0; m_tag = '0; m_oop = '0;
    m_ov1 = '0; m_ov2 = '0; m_oimm = '0; m_opc = '0;
  endtask

  task automatic snoop(input logic [3:0] t, input logic [31:0] v,
                       output logic [3:0] to, output logic [31:0] vo);
    to = t; vo = v;
    if (t != 0 && t == in_alu_cdb_tag) begin to = 0; vo = in_alu_cdb_value; end
    else if (t != 0 && t == in_lsb_cdb_tag) begin to = 0; vo = in_lsb_cdb_value; end
  endtask

  task automatic model_step();
    int d, f, n;
    if (!rdy) return;
    if (in_rollback) begin
      for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
      m_tag = 0; m_full = 0;
      return;
    end
    d = -1; f = -1;
    for (int i = 0; i < RS; i++) begin
      if (d < 0 && m_busy[i] && m_t1[i] == 0 && m_t2[i] == 0) d = i;
      if (f < 0 && !m_busy[i]) f = i;
    end
    if (d >= 0) begin
      m_tag = m_rob[d]; m_oop = m_op[d]; m_ov1 = m_v1[d]; m_ov2 = m_v2[d];
      m_oimm = m_imm[d]; m_opc = m_pc[d]; m_busy[d] = 0;
    end else m_tag = 0;
    for (int i = 0; i < RS; i++)
      if (m_busy[i]) begin
        snoop(m_t1[i], m_v1[i], m_t1[i], m_v1[i]);
        snoop(m_t2[i], m_v2[i], m_t2[i], m_v2[i]);
      end
    if (in_dec_rob_tag != 0) begin
      total++;
      if (f < 0) begin
        bad++;
        $display("FAIL issue_drop: issue tag %0d with no free slot", in_dec_rob_tag);
      end else begin
        m_busy[f] = 1; m_rob[f] = in_dec_rob_tag; m_op[f] = in_dec_op;
        m_imm[f] = in_dec_imm; m_pc[f] = in_dec_pc;
        snoop(in_dec_tag1, in_dec_value1, m_t1[f], m_v1[f]);
        snoop(in_dec_tag2, in_dec_value2, m_t2[f], m_v2[f]);
      end
    end
    n = 0;
    for (int i = 0; i < RS; i++) if (m_busy[i]) n++;
    m_full = (RS - n) < 2;
  endtask

  task automatic compare();
    chk("rob_tag", 32'(out_alu_rob_tag), 32'(m_tag));
    chk("full", 32'(out_full), 32'(m_full));
    if (m_tag != 0) begin
      chk("op", 32'(out_alu_op), 32'(m_oop));
      chk("value1", out_alu_value1, m_ov1);
      chk("value2", out_alu_value2, m_ov2);
      chk("imm", out_alu_imm, m_oimm);
      chk("pc", out_alu_pc, m_opc);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    in_rollback = 0; in_dec_rob_tag = 0; in_dec_op = 0; in_dec_value1 = 0; in_dec_value2 = 0;
    in_dec_tag1 = 0; in_dec_tag2 = 0; in_dec_imm = 0; in_dec_pc = 0;
    in_alu_cdb_tag = 0; in_alu_cdb_value = 0; in_lsb_cdb_tag = 0; in_lsb_cdb_value = 0;
  endtask

  task automatic issue(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [3:0] t1, input logic [3:0] t2);
    idle();
    in_dec_rob_tag = rob; in_dec_op = 6'd1; in_dec_value1 = v1; in_dec_value2 = v2;
    in_dec_tag1 = t1; in_dec_tag2 = t2; in_dec_imm = 32'h100 + 32'(rob);
    in_dec_pc = 32'h1000 + 32'(rob) * 4;
  endtask

  initial begin
    rst = 0; rdy = 1; idle(); model_reset();
    @(negedge clk);
    chk("reset_tag", 32'(out_alu_rob_tag), 0);
    chk("reset_full", 32'(out_full), 0);
    chk("reset_v1", out_alu_value1, 0);
    rst = 1;

    // ADD with ready operands
    issue(5, 3, 4, 0, 0); cyc();
    idle(); cyc();
    chk("add_tag", 32'(out_alu_rob_tag), 5);
    chk("add_op", 32'(out_alu_op), 1);
    chk("add_v1", out_alu_value1, 3);
    chk("add_v2", out_alu_value2, 4);
    cyc();
    chk("add_after", 32'(out_alu_rob_tag), 0);

    // pending operand woken by ALU CDB
    issue(2, 0, 9, 7, 0); cyc();
    idle();
    for (int k = 0; k < 3; k++) begin cyc(); chk("pend_wait", 32'(out_alu_rob_tag), 0); end
    in_alu_cdb_tag = 7; in_alu_cdb_value = 32'h55; cyc();
    chk("pend_wake_edge", 32'(out_alu_rob_tag), 0);
    idle(); cyc();
    chk("pend_tag", 32'(out_alu_rob_tag), 2);
    chk("pend_v1", out_alu_value1, 32'h55);

    // same-cycle bypass from LSB CDB
    issue(3, 1, 0, 0, 6); in_lsb_cdb_tag = 6; in_lsb_cdb_value = 32'hDEADBEEF; cyc();
    idle(); cyc();
    chk("byp_tag", 32'(out_alu_rob_tag), 3);
    chk("byp_v2", out_alu_value2, 32'hDEADBEEF);

    // fill to 15 waiting entries, then release all with one broadcast
    for (int k = 1; k <= 15; k++) begin
      issue(4'(k), 32'(k), 32'(k * 2), 9, 0); cyc();
      if (k == 14) chk("fill14_full", 32'(out_full), 0);
      if (k == 15) chk("fill15_full", 32'(out_full), 1);
    end
    idle(); in_alu_cdb_tag = 9; in_alu_cdb_value = 32'h99; cyc();
    chk("fill_wake_full", 32'(out_full), 1);
    idle();
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk("fill_order", 32'(out_alu_rob_tag), 32'(k));
      if (k == 1) chk("fill_drop_full", 32'(out_full), 0);
    end
    cyc();

    // rollback with a same-cycle issue
    for (int k = 1; k <= 4; k++) begin issue(4'(k), 0, 0, 10, 0); cyc(); end
    issue(5, 1, 1, 0, 0); in_rollback = 1; cyc();
    chk("rb_tag", 32'(out_alu_rob_tag), 0);
    chk("rb_full", 32'(out_full), 0);
    idle(); in_alu_cdb_tag = 10; in_alu_cdb_value = 1; cyc();
    idle(); cyc();
    chk("rb_stale", 32'(out_alu_rob_tag), 0);

    // rdy=0 freezes a visible dispatch and a ready entry
    issue(4, 7, 8, 0, 0); cyc();
    issue(6, 11, 12, 0, 0); cyc();
    chk("frz_first", 32'(out_alu_rob_tag), 4);
    idle(); rdy = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("frz_tag", 32'(out_alu_rob_tag), 4);
      chk("frz_v1", out_alu_value1, 7);
    end
    rdy = 1; cyc();
    chk("frz_release", 32'(out_alu_rob_tag), 6);

    // async reset mid-cycle with an entry still waiting
    issue(8, 1, 2, 0, 0); cyc();
    issue(9, 3, 4, 0, 0); cyc();
    #1 rst = 0;
    #1 chk("async_tag", 32'(out_alu_rob_tag), 0);
    chk("async_v1", out_alu_value1, 0);
    model_reset();
    idle();
    @(negedge clk); rst = 1;
    cyc();
    chk("post_reset_tag", 32'(out_alu_rob_tag), 0);

    // random traffic
    for (int c = 0; c < 500; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) != 0 && !m_full) begin
        in_dec_rob_tag = 4'($urandom_range(1, 15));
        in_dec_op = 6'($urandom); in_dec_value1 = $urandom; in_dec_value2 = $urandom;
        in_dec_imm = $urandom; in_dec_pc = $urandom;
        in_dec_tag1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        in_dec_tag2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      if ($urandom_range(0, 1) != 0) begin
        in_alu_cdb_tag = 4'($urandom_range(1, 15)); in_alu_cdb_value = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        in_lsb_cdb_tag = 4'($urandom_range(1, 15)); in_lsb_cdb_value = $urandom;
        if (in_lsb_cdb_tag == in_alu_cdb_tag) in_lsb_cdb_tag = 0;
      end
      if ($urandom_range(0, 60) == 0) in_rollback = 1;
      cyc();
    end
    idle(); rdy = 1;
    for (int k = 0; k < 4; k++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
